// File: rtl/bist_signature_analyzer_pkg.sv
// bist_pkg: shared types and constants for the signature analyzer
package bist_pkg;
  typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} state_t;
  localparam int MISR_W = 4;
  localparam logic [MISR_W-1:0] FB_TAPS = 4'b0011;
  localparam logic [MISR_W-1:0] DEF_GOLDEN_SIG = 4'b0010;
  localparam int DEF_N_PATTERNS = 8;
  function automatic logic [1:0] fa_resp(input logic [2:0] p);
    return {^p, (p[2] & p[1]) | (p[2] & p[0]) | (p[1] & p[0])};
  endfunction
endpackage

// File: rtl/bist_misr4.sv
// bist_misr4: 4-bit multiple-input signature register with seed load
import bist_pkg::*;
module bist_misr4 (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [MISR_W-1:0] seed,
  input  logic              en,
  input  logic [1:0]        d,
  output logic [MISR_W-1:0] sig
);
  logic [MISR_W-1:0] nxt;
  // shift up, fold the MSB back through the feedback taps, xor in the response
  always_comb nxt = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? FB_TAPS : '0) ^ {{(MISR_W-2){1'b0}}, d};
  // reset and load both seed the register; en absorbs one response
  always_ff @(posedge clock)
    if (!reset || load) sig <= seed;
    else if (en) sig <= nxt;
endmodule

// File: rtl/bist_signature_analyzer.sv
// bist_signature_analyzer: MISR-based output response analyzer; ORA_DIRECT_COMPARE_EN adds per-sample golden compare
import bist_pkg::*;
module bist_signature_analyzer #(
  parameter int N_PATTERNS = DEF_N_PATTERNS,
  parameter logic [MISR_W-1:0] SEED = 4'b0000,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = DEF_GOLDEN_SIG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              testmode,
  input  logic              resp_valid,
  input  logic [1:0]        cut_resp,
  input  logic [2:0]        pattern,
  output logic [MISR_W-1:0] signature,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fault_detected,
  output logic [7:0]        first_fail_idx
);
  state_t state;
  logic [7:0] count;
  logic load, absorb, last;
  always_comb load = (state == IDLE) & testmode;
  always_comb absorb = (state == COMPACT) & testmode & resp_valid;
  always_comb last = (count + 8'd1) == 8'(N_PATTERNS);
`ifndef ORA_DIRECT_COMPARE_EN
  logic unused_pattern;
  always_comb unused_pattern = ^pattern;
`endif
  bist_misr4 u_misr (
    .clock(clock),
    .reset(reset),
    .load (load),
    .seed (SEED),
    .en   (absorb),
    .d    (cut_resp),
    .sig  (signature)
  );
  // run control: start, compaction count, single-cycle compare, result hold and abort
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fault_detected <= 1'b0;
      first_fail_idx <= '0;
    end else
      case (state)
        IDLE:
          if (testmode) begin
            state <= COMPACT;
            count <= '0;
            busy <= 1'b1;
            fault_detected <= 1'b0;
            first_fail_idx <= '0;
          end
        COMPACT:
          if (!testmode) begin
            state <= IDLE;
            busy <= 1'b0;
            pass <= 1'b0;
            done <= 1'b0;
          end else if (resp_valid) begin
            count <= count + 8'd1;
            if (last) state <= COMPARE;
`ifdef ORA_DIRECT_COMPARE_EN
            if (!fault_detected && cut_resp != fa_resp(pattern)) begin
              fault_detected <= 1'b1;
              first_fail_idx <= count;
            end
`endif
          end
        COMPARE: begin
          state <= testmode ? DONE : IDLE;
          busy <= 1'b0;
          if (testmode) begin
            pass <= (signature == GOLDEN_SIG) & ~fault_detected;
            if (signature != GOLDEN_SIG) fault_detected <= 1'b1;
          end
        end
        default:
          if (!testmode) begin
            state <= IDLE;
            done <= 1'b0;
            pass <= 1'b0;
          end else done <= 1'b1;
      endcase
endmodule

// File: doc/bist_signature_analyzer.md
BIST_SIGNATURE_ANALYZER -- requirements
Module: bist_signature_analyzer

Interface
REQ-001 Parameter N_PATTERNS, default 8, number of compacted CUT responses per test run (1..255).
REQ-002 Parameter SEED, default 4'b0000, MISR value loaded at start of each run.
REQ-003 Parameter GOLDEN_SIG, default 4'b0010, expected fault-free signature for 8 exhaustive full-adder patterns 000..111 in ascending order.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only on rising clock edge.
REQ-006 testmode  input  1  run enable; high starts/holds a test run, low aborts or releases results.
REQ-007 resp_valid  input  1  cut_resp is valid this cycle and shall be compacted.
REQ-008 cut_resp  input  2  CUT response {sum, cout}; bit1 = sum, bit0 = cout.
REQ-009 pattern  input  3  applied pattern {a, b, cin} aligned with cut_resp; used only under ORA_DIRECT_COMPARE_EN.
REQ-010 signature  output  4  current MISR contents.
REQ-011 busy  output  1  high in COMPACT and COMPARE.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  high in DONE when signature equals GOLDEN_SIG and no direct-compare fault.
REQ-014 fault_detected  output  1  sticky fault flag for the current run.
REQ-015 first_fail_idx  output  8  sample index of first direct-compare mismatch; 0 when macro absent.

Function
REQ-016 FSM states IDLE, COMPACT, COMPARE, DONE; all outputs registered.
REQ-017 IDLE -> COMPACT when testmode=1; on that edge signature<=SEED, count<=0, fault_detected<=0, first_fail_idx<=0.
REQ-018 In COMPACT, each edge with resp_valid=1 updates MISR and increments count; resp_valid=0 holds both.
REQ-019 MISR update (d=cut_resp, fb=s[3]): s0'=fb^d0, s1'=s0^fb^d1, s2'=s1, s3'=s2.
REQ-020 COMPACT -> COMPARE on the edge that absorbs sample N_PATTERNS (count reaches N_PATTERNS); no further samples absorbed.
REQ-021 COMPARE lasts exactly one cycle; on exit sets pass=(signature==GOLDEN_SIG)&~fault_detected, sets fault_detected if signature!=GOLDEN_SIG, enters DONE.
REQ-022 DONE holds signature, pass, fault_detected, first_fail_idx stable while testmode=1; DONE -> IDLE when testmode=0, clearing done and pass only.
REQ-023 testmode=0 in COMPACT or COMPARE aborts to IDLE next edge; pass=0, done=0, signature retains partial value, no COMPARE performed.
REQ-024 Count is 8-bit; no wrap possible since run ends at N_PATTERNS.
REQ-025 Latency: done rises two edges after the edge absorbing the last sample.

Reset
REQ-026 reset=0 at a rising edge forces IDLE, signature=SEED, count=0, busy=0, done=0, pass=0, fault_detected=0, first_fail_idx=0, regardless of state or testmode.
REQ-027 reset takes priority over all other inputs, including mid-run; run restarts only after reset=1 with testmode=1.

Configuration
REQ-028 Macro ORA_DIRECT_COMPARE_EN defined: each absorbed sample is also compared with golden full-adder of pattern; first mismatch sets fault_detected on that same edge and latches first_fail_idx=count; later mismatches do not change first_fail_idx.
REQ-029 Macro undefined: pattern ignored, first_fail_idx tied 0, fault_detected changes only in COMPARE/reset/start.

Structure
REQ-030 Package bist_pkg holds state enum, MISR width (4), feedback tap constants, default GOLDEN_SIG and N_PATTERNS.
REQ-031 MISR register and update logic in sub-module bist_misr4 (ports clock, reset, load, seed, en, d, sig).

Verification
REQ-032 Fault-free: testmode=1, 8 valid responses 00,10,10,01,10,01,01,11 -> signature sequence 0000,0010,0110,1101,1011,0100,1001,0010; done=1, pass=1, fault_detected=0.
REQ-033 Sum stuck-at-0: responses 00,00,00,01,00,01,01,01 -> final signature 0100, pass=0, fault_detected=1.
REQ-034 Gaps: fault-free stream with resp_valid=0 inserted every other cycle -> same final 0010, done after 8th valid sample +2 edges.
REQ-035 Abort: testmode dropped after 4 samples -> IDLE next edge, done=0, signature 1101; re-raise testmode -> signature reloads 0000.
REQ-036 Reset mid-COMPACT (reset=0 after 5 samples) -> next edge all outputs zero, state IDLE.
REQ-037 With ORA_DIRECT_COMPARE_EN, sum stuck-at-0 stream -> fault_detected=1 on edge of sample index 1 (pattern 001), first_fail_idx=1.
